// File: rtl/synth_pkg.sv
// Shared types and helpers for the synth voice-control blocks.
package synth_pkg;
    localparam int NUM_VOICES = 4;
    localparam int NOTE_W     = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } arp_state_t;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        onehot4 = 4'b0001 << idx;
    endfunction
endpackage

// File: rtl/rr_next_key.sv
// Rotate-priority search over the four key slots: lowest held key, or the
// first held key after the current slot (wrapping back to the current one).
module rr_next_key (
    input  logic [3:0] i_key,
    input  logic [1:0] i_idx,
    input  logic       i_after,
    output logic [1:0] o_idx,
    output logic       o_valid
);
    logic [1:0] w_base;
    logic [1:0] w_slot;

    always_comb begin
        o_idx   = 2'd0;
        o_valid = 1'b0;
        w_base  = i_after ? i_idx + 2'd1 : 2'd0;
        w_slot  = w_base;
        for (int k = 0; k < 4; k++) begin
            w_slot = w_base + 2'(k);
            if (!o_valid && i_key[w_slot]) begin
                o_valid = 1'b1;
                o_idx   = w_slot;
            end
        end
    end
endmodule

// File: rtl/arp_scheduler.sv
// Key-gate passthrough or round-robin arpeggiator: one held key owns a single
// voice gate for ARP_TIME ticks, then a GAP_TICKS gate-low retrigger gap.
module arp_scheduler #(
    parameter int NUM_VOICES = 4,
    parameter int GAP_TICKS  = 1
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         TICK,
    input  logic                         ARP_EN,
    input  logic [15:0]                  ARP_TIME,
    input  logic [NUM_VOICES-1:0]        KEY,
    input  logic [synth_pkg::NOTE_W-1:0] FREQ0,
    input  logic [synth_pkg::NOTE_W-1:0] FREQ1,
    input  logic [synth_pkg::NOTE_W-1:0] FREQ2,
    input  logic [synth_pkg::NOTE_W-1:0] FREQ3,
    output logic [NUM_VOICES-1:0]        GATE,
    output logic [synth_pkg::NOTE_W-1:0] ARP_NOTE,
    output logic [1:0]                   ARP_IDX,
    output logic                         STEP
);
    import synth_pkg::*;

    localparam logic [16:0] GAP_LEN = 17'(GAP_TICKS);

    arp_state_t            r_state, w_state;
    logic [15:0]           r_cnt, w_cnt;
    logic [NUM_VOICES-1:0] r_gate, w_gate;
    logic [NOTE_W-1:0]     r_note, w_note;
    logic [1:0]            r_idx, w_idx;
    logic                  r_step, w_step;
    // Tracks whether arp mode was already active last cycle, so that
    // enabling it always spends one cycle in IDLE with gates low.
    logic                  r_arp_on;

    logic [1:0]            w_rr_idx;
    logic                  w_rr_vld;
    logic [NOTE_W-1:0]     w_freq;
    logic [16:0]           w_inc;
    logic [16:0]           w_time;
    logic [15:0]           w_cnt_sat;
    logic                  w_start;

    rr_next_key u_rr (
        .i_key   (KEY),
        .i_idx   (r_idx),
        .i_after (r_state == GAP),
        .o_idx   (w_rr_idx),
        .o_valid (w_rr_vld)
    );

    always_comb begin
        case (w_rr_idx)
            2'd0:    w_freq = FREQ0;
            2'd1:    w_freq = FREQ1;
            2'd2:    w_freq = FREQ2;
            default: w_freq = FREQ3;
        endcase
    end

    assign w_inc     = {1'b0, r_cnt} + 17'd1;
    assign w_time    = (ARP_TIME == 16'd0) ? 17'd1 : {1'b0, ARP_TIME};
    assign w_cnt_sat = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_gate  = r_gate;
        w_note  = r_note;
        w_idx   = r_idx;
        w_step  = 1'b0;
        w_start = 1'b0;
        if (!ARP_EN) begin
            w_state = IDLE;
            w_cnt   = 16'd0;
            w_gate  = KEY;
        end else if (!r_arp_on) begin
            w_state = IDLE;
            w_cnt   = 16'd0;
            w_gate  = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_gate  = '0;
                    w_cnt   = 16'd0;
                    w_start = w_rr_vld;
                end
                PLAY: begin
                    // A released key ends the step even on a TICK cycle.
                    if (!KEY[r_idx]) begin
                        w_state = GAP;
                        w_gate  = '0;
                        w_cnt   = 16'd0;
                    end else if (TICK) begin
                        if (w_inc >= w_time) begin
                            w_state = GAP;
                            w_gate  = '0;
                            w_cnt   = 16'd0;
                        end else begin
                            w_cnt = w_cnt_sat;
                        end
                    end
                end
                GAP: begin
                    w_gate = '0;
                    if (TICK) begin
                        if (w_inc >= GAP_LEN) begin
                            w_cnt = 16'd0;
                            if (KEY == '0) w_state = IDLE;
                            else           w_start = 1'b1;
                        end else begin
                            w_cnt = w_cnt_sat;
                        end
                    end
                end
                default: begin
                    w_state = IDLE;
                    w_cnt   = 16'd0;
                    w_gate  = '0;
                end
            endcase
            if (w_start) begin
                w_state = PLAY;
                w_cnt   = 16'd0;
                w_idx   = w_rr_idx;
                w_note  = w_freq;
                w_gate  = onehot4(w_rr_idx);
                w_step  = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state  <= IDLE;
            r_cnt    <= 16'd0;
            r_gate   <= '0;
            r_note   <= '0;
            r_idx    <= 2'd0;
            r_step   <= 1'b0;
            r_arp_on <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_cnt    <= w_cnt;
            r_gate   <= w_gate;
            r_note   <= w_note;
            r_idx    <= w_idx;
            r_step   <= w_step;
            r_arp_on <= ARP_EN;
        end
    end

    assign GATE     = r_gate;
    assign ARP_NOTE = r_note;
    assign ARP_IDX  = r_idx;
    assign STEP     = r_step;
endmodule
